// File: rtl/uart_fifo_controller.sv
// uart_fifo_controller: buffered UART link controller.
// The TX FIFO feeds a transmit engine and a receive engine feeds the RX FIFO.
// Both FIFOs use valid/ready handshakes. Framing, parity and overrun errors
// are reported through sticky flags.
module uart_fifo_controller #(
    parameter int CLKS_PER_BAUD = 10416,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0,
    parameter int STOP_BITS     = 1,
    parameter int TX_DEPTH      = 16,
    parameter int RX_DEPTH      = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_uart_rx,
    output logic                        o_uart_tx,
    input  logic                        i_tx_valid,
    output logic                        o_tx_ready,
    input  logic [DATA_BITS-1:0]        i_tx_data,
    output logic                        o_rx_valid,
    input  logic                        i_rx_ready,
    output logic [DATA_BITS-1:0]        o_rx_data,
    output logic [$clog2(TX_DEPTH):0]   o_tx_level,
    output logic [$clog2(RX_DEPTH):0]   o_rx_level,
    output logic                        o_tx_idle,
    output logic                        o_rx_overrun,
    output logic                        o_frame_err,
    output logic                        o_parity_err,
    input  logic                        i_err_clear
);

    localparam int TPW       = $clog2(TX_DEPTH);
    localparam int RPW       = $clog2(RX_DEPTH);
    localparam int TLW       = TPW + 1;
    localparam int RLW       = RPW + 1;
    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BAUD;
    localparam int CW        = $clog2(STOP_CLKS + 1);

    localparam logic [CW-1:0]  C_BIT_END  = CW'(CLKS_PER_BAUD - 1);
    localparam logic [CW-1:0]  C_HALF_END = CW'(CLKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0]  C_STOP_END = CW'(STOP_CLKS - 1);
    localparam logic [2:0]     C_LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [TLW-1:0] C_TX_FULL  = TLW'(TX_DEPTH);
    localparam logic [RLW-1:0] C_RX_FULL  = RLW'(RX_DEPTH);
    localparam logic           C_PAR_EN   = (PARITY_EN != 0);
    localparam logic           C_ODD      = (PARITY_ODD != 0);

    // Parity of a data word, inverted for odd parity.
    function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ C_ODD;
    endfunction

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] r_tx_mem [TX_DEPTH];
    logic [TPW-1:0]       r_tx_wr;
    logic [TPW-1:0]       r_tx_rd;
    logic [TLW-1:0]       r_tx_level;
    logic                 w_tx_push;
    logic                 w_tx_pop;
    logic [DATA_BITS-1:0] w_tx_head;

    // ---------------- TX engine ----------------
    tx_state_t            r_tx_state;
    logic [CW-1:0]        r_tx_cnt;
    logic [2:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx_line;
    logic                 r_tx_idle;
    logic                 w_tx_bit_end;
    logic                 w_tx_stop_end;

    // ---------------- RX engine ----------------
    logic                 r_rx_sync1;
    logic                 r_rx_sync2;
    logic                 w_rx_line;
    rx_state_t            r_rx_state;
    logic [CW-1:0]        r_rx_cnt;
    logic [2:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_ok;
    logic                 w_rx_bit_end;
    logic                 w_rx_half_end;
    logic                 w_rx_stop_sample;
    logic                 w_rx_push_req;
    logic                 w_frame_set;
    logic                 w_par_set;

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] r_rx_mem [RX_DEPTH];
    logic [RPW-1:0]       r_rx_wr;
    logic [RPW-1:0]       r_rx_rd;
    logic [RLW-1:0]       r_rx_level;
    logic                 w_rx_valid;
    logic                 w_rx_full;
    logic                 w_rx_pop;
    logic                 w_rx_push;
    logic                 w_overrun_set;

    logic                 r_overrun;
    logic                 r_frame_err;
    logic                 r_parity_err;

    assign o_tx_ready    = (r_tx_level != C_TX_FULL);
    assign w_tx_push     = i_tx_valid && o_tx_ready;
    assign w_tx_head     = r_tx_mem[r_tx_rd];
    assign w_tx_bit_end  = (r_tx_cnt == C_BIT_END);
    assign w_tx_stop_end = (r_tx_cnt == C_STOP_END);
    // The engine takes a word when idle, or straight out of the last stop
    // period so that back-to-back frames have no gap.
    assign w_tx_pop      = (r_tx_level != '0) &&
                           ((r_tx_state == TX_IDLE) ||
                            ((r_tx_state == TX_STOP) && w_tx_stop_end));

    // TX FIFO storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= i_tx_data;
    end

    // TX FIFO pointers and exact occupancy count.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_tx_level <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            unique case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_level <= r_tx_level + 1'b1;
                2'b01:   r_tx_level <= r_tx_level - 1'b1;
                default: r_tx_level <= r_tx_level;
            endcase
        end
    end

    // TX FSM; the line is registered from the current state, so the whole
    // frame appears on the pin one cycle after the state that produces it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
            r_tx_idle  <= 1'b1;
        end else begin
            r_tx_idle <= (r_tx_state == TX_IDLE) && (r_tx_level == '0);
            unique case (r_tx_state)
                TX_IDLE: begin
                    r_tx_line <= 1'b1;
                    if (w_tx_pop) begin
                        r_tx_shift <= w_tx_head;
                        r_tx_par   <= f_parity(w_tx_head);
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    r_tx_line <= 1'b0;
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    r_tx_line <= r_tx_shift[0];
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_shift <= r_tx_shift >> 1;
                        if (r_tx_bit == C_LAST_BIT) begin
                            r_tx_state <= C_PAR_EN ? TX_PARITY : TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_PARITY: begin
                    r_tx_line <= r_tx_par;
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    r_tx_line <= 1'b1;
                    if (w_tx_stop_end) begin
                        r_tx_cnt <= '0;
                        if (w_tx_pop) begin
                            r_tx_shift <= w_tx_head;
                            r_tx_par   <= f_parity(w_tx_head);
                            r_tx_state <= TX_START;
                        end else begin
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx_line  <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign o_uart_tx = r_tx_line;
    assign o_tx_idle = r_tx_idle;
    assign o_tx_level = r_tx_level;

    // Two-flop synchroniser for the asynchronous serial input, idle high.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
        end else begin
            r_rx_sync1 <= i_uart_rx;
            r_rx_sync2 <= r_rx_sync1;
        end
    end

    assign w_rx_line        = r_rx_sync2;
    assign w_rx_bit_end     = (r_rx_cnt == C_BIT_END);
    assign w_rx_half_end    = (r_rx_cnt == C_HALF_END);
    assign w_rx_stop_sample = (r_rx_state == RX_STOP) && w_rx_bit_end;
    assign w_rx_push_req    = w_rx_stop_sample && w_rx_line && (!C_PAR_EN || r_rx_par_ok);
    assign w_frame_set      = w_rx_stop_sample && !w_rx_line;
    assign w_par_set        = (r_rx_state == RX_PARITY) && w_rx_bit_end &&
                              (w_rx_line != f_parity(r_rx_shift));

    // RX FSM: centre-samples each bit after qualifying the start bit at half a bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_par_ok <= 1'b1;
        end else begin
            unique case (r_rx_state)
                RX_IDLE: begin
                    if (!w_rx_line) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_rx_half_end) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= w_rx_line ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx_line, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == C_LAST_BIT) begin
                            r_rx_state <= C_PAR_EN ? RX_PARITY : RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt    <= '0;
                        r_rx_par_ok <= !w_par_set;
                        r_rx_state  <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= w_rx_line ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (w_rx_line) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign w_rx_valid    = (r_rx_level != '0);
    assign w_rx_full     = (r_rx_level == C_RX_FULL);
    assign w_rx_pop      = w_rx_valid && i_rx_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_rx_push     = w_rx_push_req && (!w_rx_full || w_rx_pop);
    assign w_overrun_set = w_rx_push_req && w_rx_full && !w_rx_pop;

    // RX FIFO storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wr] <= r_rx_shift;
    end

    // RX FIFO pointers and exact occupancy count.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_rx_level <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            unique case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_level <= r_rx_level + 1'b1;
                2'b01:   r_rx_level <= r_rx_level - 1'b1;
                default: r_rx_level <= r_rx_level;
            endcase
        end
    end

    assign o_rx_valid = w_rx_valid;
    assign o_rx_data  = w_rx_valid ? r_rx_mem[r_rx_rd] : '0;
    assign o_rx_level = r_rx_level;

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_overrun_set)    r_overrun <= 1'b1;
            else if (i_err_clear) r_overrun <= 1'b0;
            if (w_frame_set)      r_frame_err <= 1'b1;
            else if (i_err_clear) r_frame_err <= 1'b0;
            if (w_par_set)        r_parity_err <= 1'b1;
            else if (i_err_clear) r_parity_err <= 1'b0;
        end
    end

    assign o_rx_overrun = r_overrun;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed self-checking bench for uart_fifo_controller at 16 clocks per bit.
// u_dut1 is 8N1 with a 4-entry RX FIFO and optional loopback;
// u_dut2 is 8O1 and is used for the parity checks.
module tb_uart_fifo_controller;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       loop;
    logic       rx1_drv, rx2_drv;
    int         cyc = 0;
    int         tests_run = 0;
    int         tests_failed = 0;

    logic       tx1, tx_valid1, tx_ready1, rx_valid1, rx_ready1, clr1;
    logic [7:0] tx_data1, rx_data1;
    logic [4:0] tx_level1;
    logic [2:0] rx_level1;
    logic       tx_idle1, ovr1, ferr1, perr1, rx_pin1;

    logic       tx2, tx_valid2, tx_ready2, rx_valid2, rx_ready2, clr2;
    logic [7:0] tx_data2, rx_data2;
    logic [2:0] tx_level2, rx_level2;
    logic       tx_idle2, ovr2, ferr2, perr2;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign rx_pin1 = loop ? tx1 : rx1_drv;

    uart_fifo_controller #(
        .CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
        .STOP_BITS(1), .TX_DEPTH(16), .RX_DEPTH(4)
    ) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_uart_rx(rx_pin1), .o_uart_tx(tx1),
        .i_tx_valid(tx_valid1), .o_tx_ready(tx_ready1), .i_tx_data(tx_data1),
        .o_rx_valid(rx_valid1), .i_rx_ready(rx_ready1), .o_rx_data(rx_data1),
        .o_tx_level(tx_level1), .o_rx_level(rx_level1), .o_tx_idle(tx_idle1),
        .o_rx_overrun(ovr1), .o_frame_err(ferr1), .o_parity_err(perr1),
        .i_err_clear(clr1)
    );

    uart_fifo_controller #(
        .CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
        .STOP_BITS(1), .TX_DEPTH(4), .RX_DEPTH(4)
    ) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_uart_rx(rx2_drv), .o_uart_tx(tx2),
        .i_tx_valid(tx_valid2), .o_tx_ready(tx_ready2), .i_tx_data(tx_data2),
        .o_rx_valid(rx_valid2), .i_rx_ready(rx_ready2), .o_rx_data(rx_data2),
        .o_tx_level(tx_level2), .o_rx_level(rx_level2), .o_tx_idle(tx_idle2),
        .o_rx_overrun(ovr2), .o_frame_err(ferr2), .o_parity_err(perr2),
        .i_err_clear(clr2)
    );

    task automatic set_pin(input int sel, input logic v);
        if (sel == 0) rx1_drv = v;
        else          rx2_drv = v;
    endtask

    // Drive one serial frame, LSB first, on the selected bench-driven pin.
    task automatic drive_frame(input int sel, input logic [7:0] d,
                               input logic with_par, input logic par_bit);
        set_pin(sel, 1'b0);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_pin(sel, d[i]);
            repeat (CPB) @(negedge clk);
        end
        if (with_par) begin
            set_pin(sel, par_bit);
            repeat (CPB) @(negedge clk);
        end
        set_pin(sel, 1'b1);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (tx1 !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b want 1", tx1); end
        tests_run++; if (tx_ready1 !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready1); end
        tests_run++; if (rx_valid1 !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid1); end
        tests_run++; if (rx_data1 !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data: got %h want 00", rx_data1); end
        tests_run++; if (tx_level1 !== 5'd0) begin tests_failed++; $display("FAIL reset_tx_level: got %0d want 0", tx_level1); end
        tests_run++; if (rx_level1 !== 3'd0) begin tests_failed++; $display("FAIL reset_rx_level: got %0d want 0", rx_level1); end
        tests_run++; if (tx_idle1 !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_idle: got %b want 1", tx_idle1); end
        tests_run++; if ({ovr1, ferr1, perr1} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {ovr1, ferr1, perr1}); end
    endtask

    task automatic test_tx_frame();
        logic [7:0] d;
        logic       exp;
        int         errs;
        d = 8'hA5;
        errs = 0;
        tx_data1 = d;
        tx_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid1 = 1'b0;
        tests_run++; if (tx_level1 !== 5'd1) begin tests_failed++; $display("FAIL tx_level_after_write: got %0d want 1", tx_level1); end
        tests_run++; if (tx1 !== 1'b1) begin tests_failed++; $display("FAIL tx_line_k: got %b want 1", tx1); end
        @(negedge clk);
        tests_run++; if (tx_idle1 !== 1'b0) begin tests_failed++; $display("FAIL tx_idle_fall: got %b want 0", tx_idle1); end
        tests_run++; if (tx1 !== 1'b1) begin tests_failed++; $display("FAIL tx_line_k1: got %b want 1", tx1); end
        @(negedge clk);
        for (int i = 0; i < 160; i++) begin
            if (i < 16)       exp = 1'b0;
            else if (i < 144) exp = d[(i - 16) / 16];
            else              exp = 1'b1;
            if (tx1 !== exp) errs++;
            if (i != 159) @(negedge clk);
        end
        tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL tx_a5_waveform: got %0d wrong cycles want 0", errs); end
        tests_run++; if (tx_idle1 !== 1'b0) begin tests_failed++; $display("FAIL tx_idle_in_stop: got %b want 0", tx_idle1); end
        @(negedge clk);
        tests_run++; if (tx_idle1 !== 1'b1) begin tests_failed++; $display("FAIL tx_idle_rise: got %b want 1", tx_idle1); end
    endtask

    task automatic test_loopback();
        logic [7:0] words [3];
        int         n;
        int         t0;
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
        loop = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tx_data1 = words[i];
            tx_valid1 = 1'b1;
            @(negedge clk);
        end
        tx_valid1 = 1'b0;
        n = 0;
        while (tx1 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        tests_run++; if (n >= 20) begin tests_failed++; $display("FAIL loop_start_seen: got timeout want start bit"); end
        t0 = cyc;
        while (cyc < t0 + 159) @(negedge clk);
        tests_run++; if (tx1 !== 1'b1) begin tests_failed++; $display("FAIL loop_stop0: got %b want 1", tx1); end
        @(negedge clk);
        tests_run++; if (tx1 !== 1'b0) begin tests_failed++; $display("FAIL loop_start1_at_160: got %b want 0", tx1); end
        while (cyc < t0 + 176) @(negedge clk);
        tests_run++; if (tx1 !== 1'b1) begin tests_failed++; $display("FAIL loop_data1_bit0: got %b want 1", tx1); end
        while (cyc < t0 + 319) @(negedge clk);
        tests_run++; if (tx1 !== 1'b1) begin tests_failed++; $display("FAIL loop_stop1: got %b want 1", tx1); end
        @(negedge clk);
        tests_run++; if (tx1 !== 1'b0) begin tests_failed++; $display("FAIL loop_start2_at_320: got %b want 0", tx1); end
        while (cyc < t0 + 480) @(negedge clk);
        n = 0;
        while (rx_level1 !== 3'd3 && n < 200) begin @(negedge clk); n++; end
        tests_run++; if (rx_level1 !== 3'd3) begin tests_failed++; $display("FAIL loop_rx_level: got %0d want 3", rx_level1); end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rx_valid1 !== 1'b1 || rx_data1 !== words[i]) begin
                tests_failed++;
                $display("FAIL loop_rx_word%0d: got valid=%b data=%h want valid=1 data=%h", i, rx_valid1, rx_data1, words[i]);
            end
            rx_ready1 = 1'b1;
            @(negedge clk);
            rx_ready1 = 1'b0;
        end
        tests_run++; if ({ovr1, ferr1, perr1} !== 3'b000) begin tests_failed++; $display("FAIL loop_flags: got %b want 000", {ovr1, ferr1, perr1}); end
        tests_run++; if (rx_level1 !== 3'd0) begin tests_failed++; $display("FAIL loop_rx_drained: got %0d want 0", rx_level1); end
        loop = 1'b0;
    endtask

    task automatic test_overrun();
        int n;
        loop = 1'b1;
        rx_ready1 = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            tx_data1 = 8'(i * 17);
            tx_valid1 = 1'b1;
            @(negedge clk);
        end
        tx_valid1 = 1'b0;
        n = 0;
        while (tx_idle1 !== 1'b1 && n < 1200) begin @(negedge clk); n++; end
        tests_run++; if (n >= 1200) begin tests_failed++; $display("FAIL ovr_tx_done: got timeout want idle"); end
        repeat (4) @(negedge clk);
        tests_run++; if (rx_level1 !== 3'd4) begin tests_failed++; $display("FAIL ovr_level: got %0d want 4", rx_level1); end
        tests_run++; if (ovr1 !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag: got %b want 1", ovr1); end
        tests_run++; if (rx_data1 !== 8'h11) begin tests_failed++; $display("FAIL ovr_head: got %h want 11", rx_data1); end
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        tests_run++; if (ovr1 !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %b want 0", ovr1); end
        for (int i = 1; i <= 4; i++) begin
            tests_run++;
            if (rx_data1 !== 8'(i * 17)) begin
                tests_failed++;
                $display("FAIL ovr_word%0d: got %h want %h", i, rx_data1, 8'(i * 17));
            end
            rx_ready1 = 1'b1;
            @(negedge clk);
            rx_ready1 = 1'b0;
        end
        loop = 1'b0;
    endtask

    task automatic test_break();
        rx1_drv = 1'b0;
        repeat (200) @(negedge clk);
        tests_run++; if (ferr1 !== 1'b1) begin tests_failed++; $display("FAIL brk_frame_err: got %b want 1", ferr1); end
        tests_run++; if (rx_level1 !== 3'd0) begin tests_failed++; $display("FAIL brk_no_push: got %0d want 0", rx_level1); end
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        repeat (20 * CPB - 201) @(negedge clk);
        tests_run++; if (ferr1 !== 1'b0) begin tests_failed++; $display("FAIL brk_held_wait_high: got %b want 0", ferr1); end
        rx1_drv = 1'b1;
        repeat (8) @(negedge clk);
        drive_frame(0, 8'h5A, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        tests_run++; if (rx_level1 !== 3'd1) begin tests_failed++; $display("FAIL brk_recover_level: got %0d want 1", rx_level1); end
        tests_run++; if (rx_data1 !== 8'h5A) begin tests_failed++; $display("FAIL brk_recover_data: got %h want 5a", rx_data1); end
        tests_run++; if (ferr1 !== 1'b0) begin tests_failed++; $display("FAIL brk_recover_ferr: got %b want 0", ferr1); end
        rx_ready1 = 1'b1;
        @(negedge clk);
        rx_ready1 = 1'b0;
    endtask

    task automatic test_parity();
        // 0x07 has three ones: the odd-parity bit is 0, so 1 is wrong.
        drive_frame(1, 8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        tests_run++; if (perr2 !== 1'b1) begin tests_failed++; $display("FAIL par_err_set: got %b want 1", perr2); end
        tests_run++; if (rx_level2 !== 3'd0) begin tests_failed++; $display("FAIL par_discard: got %0d want 0", rx_level2); end
        tests_run++; if (ferr2 !== 1'b0) begin tests_failed++; $display("FAIL par_no_ferr: got %b want 0", ferr2); end
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        tests_run++; if (perr2 !== 1'b0) begin tests_failed++; $display("FAIL par_clear: got %b want 0", perr2); end
        drive_frame(1, 8'h07, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        tests_run++; if (rx_level2 !== 3'd1 || rx_data2 !== 8'h07) begin tests_failed++; $display("FAIL par_good_word: got level=%0d data=%h want level=1 data=07", rx_level2, rx_data2); end
        tests_run++; if (perr2 !== 1'b0) begin tests_failed++; $display("FAIL par_good_no_err: got %b want 0", perr2); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] words [4];
        int         errs;
        words[0] = 8'h00; words[1] = 8'h12; words[2] = 8'h34; words[3] = 8'h56;
        for (int i = 0; i < 4; i++) begin
            tx_data1 = words[i];
            tx_valid1 = 1'b1;
            @(negedge clk);
        end
        tx_valid1 = 1'b0;
        repeat (40) @(negedge clk);
        tests_run++; if (tx_level1 !== 5'd3) begin tests_failed++; $display("FAIL rst_pre_level: got %0d want 3", tx_level1); end
        tests_run++; if (tx1 !== 1'b0) begin tests_failed++; $display("FAIL rst_pre_line: got %b want 0", tx1); end
        #1;
        rst = 1'b1;
        #1;
        tests_run++; if (tx1 !== 1'b1) begin tests_failed++; $display("FAIL rst_async_line: got %b want 1", tx1); end
        tests_run++; if (tx_level1 !== 5'd0) begin tests_failed++; $display("FAIL rst_async_level: got %0d want 0", tx_level1); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || tx_level1 !== 5'd0 || tx_idle1 !== 1'b1) errs++;
        end
        tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL rst_no_restart: got %0d bad cycles want 0", errs); end
        tx_data1 = 8'h81;
        tx_valid1 = 1'b1;
        @(negedge clk);
        tx_valid1 = 1'b0;
        @(negedge clk);
        tests_run++; if (tx1 !== 1'b1) begin tests_failed++; $display("FAIL rst_new_k1: got %b want 1", tx1); end
        @(negedge clk);
        tests_run++; if (tx1 !== 1'b0) begin tests_failed++; $display("FAIL rst_new_start: got %b want 0", tx1); end
    endtask

    initial begin
        rst = 1'b0; loop = 1'b0; rx1_drv = 1'b1; rx2_drv = 1'b1;
        tx_valid1 = 1'b0; tx_data1 = 8'h00; rx_ready1 = 1'b0; clr1 = 1'b0;
        tx_valid2 = 1'b0; tx_data2 = 8'h00; rx_ready2 = 1'b0; clr2 = 1'b0;
        @(negedge clk);
        test_reset();
        test_tx_frame();
        test_loopback();
        test_overrun();
        test_break();
        test_parity();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule
